br_ctrl: RTL and testbench
==========================

# br_ctrl

Branch resolution controller for the CPU pipeline. It accepts one decoded conditional or unconditional branch at a time and waits for both source operands to become ready. It then evaluates the condition with the `br_logic` comparator, compares the outcome against the decode-stage prediction, and on a mispredict issues a fetch redirect followed by a one-cycle pipeline flush. It also keeps saturating branch and mispredict statistics counters.

## Interface
- `CNT_W`, 16, width of the statistics counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `kill` in 1: upstream squash; aborts any in-flight branch.
- `in_valid` in 1: branch request valid.
- `in_ready` out 1: controller can accept a branch.
- `in_pc` in 32: branch PC.
- `in_imm` in 32 signed: branch offset.
- `in_fun` in `br_fun_t`: comparison function.
- `in_uncond` in 1: unconditional jump; no operands needed, always taken.
- `in_pred_taken` in 1: decode prediction.
- `rs1_val`, `rs2_val` in 32 each: forwarded operand values.
- `rs1_rdy`, `rs2_rdy` in 1 each: operand-ready flags from the scoreboard.
- `redir_valid` out 1: redirect request to fetch.
- `redir_ready` in 1: fetch accepts the redirect.
- `redir_pc` out 32: redirect target.
- `flush` out 1: one-cycle flush pulse.
- `busy` out 1: state is not IDLE.
- `stat_br_cnt` out `CNT_W`: resolved branches.
- `stat_mispred_cnt` out `CNT_W`: mispredicted branches.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`, capture pc, imm, fun, uncond, pred. Go to WAIT_OPS.
  - WAIT_OPS:
    - if `in_uncond`, or `rs1_rdy` && `rs2_rdy`: capture `rs1_val` and `rs2_val` (these are don't-care when `in_uncond`), go to EVAL.
    - else stay.
  - EVAL:
    - taken = uncond | bcomp, where bcomp comes from `br_logic` on the captured operands.
    - mispred = taken != pred.
    - Increment `stat_br_cnt`. If mispred, increment `stat_mispred_cnt`.
    - If mispred, go to REDIRECT with `redir_pc` = taken ? pc+imm : pc+4. Otherwise go to IDLE.
  - REDIRECT: hold `redir_valid`=1 and a stable `redir_pc` until `redir_ready`. On the handshake, go to IDLE and register `flush`=1 for the next cycle.
- `kill` has priority over every transition:
  - next state is IDLE;
  - no counter update, no redirect, no flush;
  - `in_valid` in the same cycle as `kill` is not accepted, because `in_ready` is gated by `!kill`.
- Arithmetic is modulo 2^32. Example: pc=0xFFFF_FFFC with not-taken gives `redir_pc`=0x0000_0000. Negative imm is sign-correct.
- Counters saturate at all-ones and never wrap.
- Reset values: state=IDLE, `in_ready`=1, `redir_valid`=0, `redir_pc`=0, `flush`=0, `busy`=0, both counters 0, captured registers 0.

## Timing
- Handshake at edge E0 (IDLE, `in_valid`): WAIT_OPS in cycle 1.
- Operands ready in cycle 1: EVAL in cycle 2. Counters update at the end of cycle 2.
- Mispredict: `redir_valid` rises in cycle 3. Handshake in cycle k gives `flush`=1 in cycle k+1 only.
- Correct prediction: IDLE in cycle 3, `in_ready`=1 in cycle 3.
- Back-to-back branches are accepted no faster than every 3 cycles.
- Every operand wait cycle adds one cycle of latency.
- `redir_valid` never drops without `redir_ready`, except on `kill` or reset.
- Reset asserted mid-operation clears everything asynchronously. A pending redirect is lost and no `flush` is emitted.
- `kill` in the same cycle as the redirect handshake: the redirect is considered not accepted, and `flush` stays 0. Fetch must qualify `redir_valid` with `!kill`.

## Structure
- `pkg_cpu_types` gains `br_ctrl_state_t` (IDLE, WAIT_OPS, EVAL, REDIRECT). It already provides `br_fun_t`.
- One sub-module: `br_logic`, instantiated on the captured operand registers.

## Test plan
- BEQ, rs1=rs2=5, pred=1, pc=0x100, imm=0x20, operands ready: no redirect; `stat_br_cnt`=1, `stat_mispred_cnt`=0; `in_ready` high again cycle 3.
- BLT, rs1=-1, rs2=1, pred=0, pc=0x200, imm=-8: `redir_pc`=0x1F8 in cycle 3; `flush` pulses one cycle after handshake; `stat_mispred_cnt`=1.
- BGE, rs1=3, rs2=7, pred=1, pc=0xFFFF_FFFC: `redir_pc`=0x0000_0000. Hold `redir_ready`=0 for 4 cycles: `redir_valid` and `redir_pc` stay stable.
- BNE with `rs2_rdy` low for 5 cycles: state stays WAIT_OPS. Values present while not ready are ignored. Values captured on the ready cycle decide the outcome.
- `kill` asserted in EVAL, and separately in REDIRECT: return to IDLE, counters unchanged, `flush`=0, no redirect.
- Counters preloaded by 65535 correct branches with `CNT_W`=16: the next branch leaves `stat_br_cnt`=0xFFFF. Async `rst_n` low mid-REDIRECT: all outputs at their reset values immediately.

Source files
------------

// File: rtl/pkg_cpu_types.sv
// Shared CPU pipeline types: branch comparison functions and the branch
// resolution controller state encoding.
package pkg_cpu_types;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_fun_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        EVAL     = 2'd2,
        REDIRECT = 2'd3
    } br_ctrl_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/br_ctrl_if.sv
// Decode/scoreboard/fetch-facing bundle of the branch resolution controller.
interface br_ctrl_if #(
    parameter int CNT_W = 16
);
    import pkg_cpu_types::*;

    logic             kill;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_imm;
    br_fun_t          in_fun;
    logic             in_uncond;
    logic             in_pred_taken;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic             rs1_rdy;
    logic             rs2_rdy;
    logic             redir_valid;
    logic             redir_ready;
    logic [31:0]      redir_pc;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] stat_br_cnt;
    logic [CNT_W-1:0] stat_mispred_cnt;

    modport master (
        output kill, in_valid, in_pc, in_imm, in_fun, in_uncond, in_pred_taken,
               rs1_val, rs2_val, rs1_rdy, rs2_rdy, redir_ready,
        input  in_ready, redir_valid, redir_pc, flush, busy,
               stat_br_cnt, stat_mispred_cnt
    );

    modport slave (
        input  kill, in_valid, in_pc, in_imm, in_fun, in_uncond, in_pred_taken,
               rs1_val, rs2_val, rs1_rdy, rs2_rdy, redir_ready,
        output in_ready, redir_valid, redir_pc, flush, busy,
               stat_br_cnt, stat_mispred_cnt
    );

endinterface

// File: rtl/br_logic.sv
// Branch condition comparator; purely combinational.
module br_logic
    import pkg_cpu_types::*;
(
    input  br_fun_t     i_fun,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        o_taken = 1'b0;
        case (i_fun)
            BR_BEQ:  o_taken = w_eq;
            BR_BNE:  o_taken = !w_eq;
            BR_BLT:  o_taken = w_lt;
            BR_BGE:  o_taken = !w_lt;
            BR_BLTU: o_taken = w_ltu;
            BR_BGEU: o_taken = !w_ltu;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_ctrl.sv
// Branch resolution controller: waits for operands, resolves the branch,
// redirects fetch and flushes the pipeline on a mispredict.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a new branch
// WAIT_OPS | branch captured, waiting for both operands (or uncond)
// EVAL     | compare captured operands, update statistics
// REDIRECT | mispredict: hold redirect until fetch accepts it
module br_ctrl
    import pkg_cpu_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    br_ctrl_if.slave  br
);

    br_ctrl_state_t   r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_imm;
    br_fun_t          r_fun;
    logic             r_uncond;
    logic             r_pred;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [31:0]      r_redir_pc;
    logic             r_flush;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic             w_cmp_taken;
    logic             w_taken;
    logic             w_mispred;
    logic [31:0]      w_target;

    br_logic u_br_logic (
        .i_fun   (r_fun),
        .i_rs1   (r_rs1),
        .i_rs2   (r_rs2),
        .o_taken (w_cmp_taken)
    );

    assign w_taken   = r_uncond | w_cmp_taken;
    assign w_mispred = (w_taken != r_pred);
    // Two's-complement add gives the sign-correct, mod-2^32 target
    assign w_target  = w_taken ? (r_pc + r_imm) : (r_pc + PC_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_imm      <= '0;
            r_fun      <= BR_BEQ;
            r_uncond   <= 1'b0;
            r_pred     <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_redir_pc <= '0;
            r_flush    <= 1'b0;
            r_br_cnt   <= '0;
            r_mis_cnt  <= '0;
        end else begin
            r_flush <= 1'b0;
            if (br.kill) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (br.in_valid) begin
                            r_pc     <= br.in_pc;
                            r_imm    <= br.in_imm;
                            r_fun    <= br.in_fun;
                            r_uncond <= br.in_uncond;
                            r_pred   <= br.in_pred_taken;
                            r_state  <= WAIT_OPS;
                        end
                    end
                    WAIT_OPS: begin
                        if (r_uncond || (br.rs1_rdy && br.rs2_rdy)) begin
                            r_rs1   <= br.rs1_val;
                            r_rs2   <= br.rs2_val;
                            r_state <= EVAL;
                        end
                    end
                    EVAL: begin
                        if (r_br_cnt != '1) begin
                            r_br_cnt <= r_br_cnt + CNT_W'(1);
                        end
                        if (w_mispred) begin
                            if (r_mis_cnt != '1) begin
                                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                            end
                            r_redir_pc <= w_target;
                            r_state    <= REDIRECT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    REDIRECT: begin
                        if (br.redir_ready) begin
                            r_flush <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // kill gates acceptance combinationally so a squashed request is never taken
    assign br.in_ready         = (r_state == IDLE) && !br.kill;
    assign br.busy             = (r_state != IDLE);
    assign br.redir_valid      = (r_state == REDIRECT);
    assign br.redir_pc         = r_redir_pc;
    assign br.flush            = r_flush;
    assign br.stat_br_cnt      = r_br_cnt;
    assign br.stat_mispred_cnt = r_mis_cnt;

endmodule

// File: tb/tb_br_ctrl.sv
// Directed bench for br_ctrl; a second instance with 4-bit counters shares
// the stimulus so counter saturation is reached in a short run.
module tb_br_ctrl;
    import pkg_cpu_types::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    br_ctrl_if #(.CNT_W(16)) bus   ();
    br_ctrl_if #(.CNT_W(4))  bus_s ();

    br_ctrl #(.CNT_W(16)) u_dut   (.clk(clk), .rst_n(rst_n), .br(bus.slave));
    br_ctrl #(.CNT_W(4))  u_dut_s (.clk(clk), .rst_n(rst_n), .br(bus_s.slave));

    assign bus_s.kill          = bus.kill;
    assign bus_s.in_valid      = bus.in_valid;
    assign bus_s.in_pc         = bus.in_pc;
    assign bus_s.in_imm        = bus.in_imm;
    assign bus_s.in_fun        = bus.in_fun;
    assign bus_s.in_uncond     = bus.in_uncond;
    assign bus_s.in_pred_taken = bus.in_pred_taken;
    assign bus_s.rs1_val       = bus.rs1_val;
    assign bus_s.rs2_val       = bus.rs2_val;
    assign bus_s.rs1_rdy       = bus.rs1_rdy;
    assign bus_s.rs2_rdy       = bus.rs2_rdy;
    assign bus_s.redir_ready   = bus.redir_ready;

    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    logic        e_busy, e_redir, e_flush;
    logic [31:0] e_pc;
    int          e_br, e_mis;
    logic [31:0] seen_pc;
    int          n_redir_cyc, n_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // ISA meaning of each branch, operands read as plain signed/unsigned integers
    function automatic logic model_taken(input br_fun_t f, input logic unc,
                                         input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        if (unc) return 1'b1;
        case (f)
            BR_BEQ:  return a == b;
            BR_BNE:  return a != b;
            BR_BLT:  return sa < sb;
            BR_BGE:  return sa >= sb;
            BR_BLTU: return a < b;
            BR_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_target(input br_fun_t f, input logic unc,
                                                 input logic [31:0] pc, input logic [31:0] imm,
                                                 input logic [31:0] a, input logic [31:0] b);
        longint t;
        if (model_taken(f, unc, a, b)) t = longint'(pc) + longint'($signed(imm));
        else                           t = longint'(pc) + 4;
        return t[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",    bus.in_ready,    32'(!e_busy && !bus.kill));
            check("busy",        bus.busy,        32'(e_busy));
            check("redir_valid", bus.redir_valid, 32'(e_redir));
            check("flush",       bus.flush,       32'(e_flush));
            if (e_redir) check("redir_pc", bus.redir_pc, e_pc);
            check("stat_br",     bus.stat_br_cnt,      sat(e_br, 16));
            check("stat_mis",    bus.stat_mispred_cnt, sat(e_mis, 16));
            check("s_busy",      bus_s.busy,           32'(e_busy));
            check("s_stat_br",   bus_s.stat_br_cnt,      sat(e_br, 4));
            check("s_stat_mis",  bus_s.stat_mispred_cnt, sat(e_mis, 4));
        end
        if (bus.redir_valid) begin
            seen_pc = bus.redir_pc;
            n_redir_cyc++;
        end
        if (bus.flush) n_flush++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e_flush = 1'b0;
    endtask

    // kill_mode: 0 none, 1 kill in EVAL, 2 kill together with the redirect handshake
    task automatic run_branch(input logic [31:0] pc, input logic [31:0] imm, input br_fun_t fun,
                              input logic unc, input logic pred,
                              input logic [31:0] a, input logic [31:0] b,
                              input int n_wait, input int n_hold, input int kill_mode);
        logic        mis;
        logic [31:0] tgt;
        mis = (model_taken(fun, unc, a, b) != pred);
        tgt = model_target(fun, unc, pc, imm, a, b);
        bus.in_valid = 1'b1;  bus.in_pc = pc;  bus.in_imm = imm;  bus.in_fun = fun;
        bus.in_uncond = unc;  bus.in_pred_taken = pred;
        tick();
        bus.in_valid = 1'b0;  bus.in_pc = 32'hDEAD_BEEF;  bus.in_imm = 32'h0BAD_0BAD;
        bus.in_pred_taken = !pred;
        e_busy = 1'b1;
        bus.rs1_val = a;  bus.rs2_val = a;  bus.rs1_rdy = !unc;  bus.rs2_rdy = 1'b0;
        repeat (n_wait) tick();
        if (!unc) begin
            bus.rs2_rdy = 1'b1;
            bus.rs2_val = b;
        end
        tick();
        bus.rs1_rdy = 1'b0;  bus.rs2_rdy = 1'b0;  bus.rs2_val = a;
        if (kill_mode == 1) begin
            bus.kill = 1'b1;
            tick();
            bus.kill = 1'b0;
            e_busy = 1'b0;
            return;
        end
        tick();
        e_br++;
        if (mis) e_mis++;
        if (!mis) begin
            e_busy = 1'b0;
            return;
        end
        e_redir = 1'b1;
        e_pc = tgt;
        repeat (n_hold) tick();
        bus.redir_ready = 1'b1;
        if (kill_mode == 2) bus.kill = 1'b1;
        tick();
        bus.redir_ready = 1'b0;
        bus.kill = 1'b0;
        e_busy = 1'b0;
        e_redir = 1'b0;
        e_flush = (kill_mode != 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.kill = 1'b0;  bus.in_valid = 1'b0;  bus.in_pc = '0;  bus.in_imm = '0;
        bus.in_fun = BR_BEQ;  bus.in_uncond = 1'b0;  bus.in_pred_taken = 1'b0;
        bus.rs1_val = '0;  bus.rs2_val = '0;  bus.rs1_rdy = 1'b0;  bus.rs2_rdy = 1'b0;
        bus.redir_ready = 1'b0;
        e_busy = 1'b0;  e_redir = 1'b0;  e_flush = 1'b0;  e_pc = '0;  e_br = 0;  e_mis = 0;
        seen_pc = '0;  n_redir_cyc = 0;  n_flush = 0;

        // model pins
        check("pin blt target", model_target(BR_BLT, 1'b0, 32'h200, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1), 32'h1F8);
        check("pin bge wrap",   model_target(BR_BGE, 1'b0, 32'hFFFF_FFFC, 32'h40, 32'd3, 32'd7), 32'h0);
        check("pin bltu",       32'(model_taken(BR_BLTU, 1'b0, 32'hFFFF_FFFF, 32'd1)), 32'd0);

        #12;
        check("rst in_ready",    bus.in_ready, 32'd1);
        check("rst busy",        bus.busy, 32'd0);
        check("rst redir_valid", bus.redir_valid, 32'd0);
        check("rst redir_pc",    bus.redir_pc, 32'd0);
        check("rst flush",       bus.flush, 32'd0);
        check("rst stat_br",     bus.stat_br_cnt, 32'd0);
        check("rst stat_mis",    bus.stat_mispred_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // correct BEQ, back in IDLE on cycle 3
        run_branch(32'h100, 32'h20, BR_BEQ, 1'b0, 1'b1, 32'd5, 32'd5, 0, 0, 0);
        check("t1 in_ready", bus.in_ready, 32'd1);
        check("t1 stat_br",  bus.stat_br_cnt, 32'd1);
        check("t1 stat_mis", bus.stat_mispred_cnt, 32'd0);

        // BLT mispredict with negative offset
        n_flush = 0;
        run_branch(32'h200, 32'hFFFF_FFF8, BR_BLT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
        check("t2 redir_pc", seen_pc, 32'h1F8);
        check("t2 flush",    bus.flush, 32'd1);
        check("t2 stat_mis", bus.stat_mispred_cnt, 32'd1);
        tick();
        check("t2 flush one cycle", 32'(n_flush), 32'd1);

        // BGE not-taken wrap-around, fetch stalls 4 cycles
        n_redir_cyc = 0;
        seen_pc = 32'h1234_5678;
        run_branch(32'hFFFF_FFFC, 32'h40, BR_BGE, 1'b0, 1'b1, 32'd3, 32'd7, 0, 4, 0);
        check("t3 redir_pc",   seen_pc, 32'h0);
        check("t3 redir hold", 32'(n_redir_cyc), 32'd5);

        // BNE with rs2 late by 5 cycles; values seen while not ready are equal
        run_branch(32'h400, 32'h10, BR_BNE, 1'b0, 1'b1, 32'd7, 32'd9, 5, 0, 0);
        check("t4 stat_br",  bus.stat_br_cnt, 32'd4);
        check("t4 stat_mis", bus.stat_mispred_cnt, 32'd2);

        // kill in EVAL, then kill during the redirect handshake
        n_flush = 0;
        n_redir_cyc = 0;
        run_branch(32'h500, 32'h8, BR_BEQ, 1'b0, 1'b0, 32'd4, 32'd4, 0, 0, 1);
        check("t5a redir", 32'(n_redir_cyc), 32'd0);
        check("t5a stat_br", bus.stat_br_cnt, 32'd4);
        run_branch(32'h600, 32'h8, BR_BLT, 1'b0, 1'b0, 32'd1, 32'd2, 0, 1, 2);
        tick();
        check("t5b no flush", 32'(n_flush), 32'd0);
        check("t5b stat_mis", bus.stat_mispred_cnt, 32'd3);

        // in_valid together with kill is not accepted
        bus.kill = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.kill = 1'b0;
        bus.in_valid = 1'b0;
        check("t6 not accepted", bus.busy, 32'd0);
        tick();

        // unconditional jump with no operands ready
        run_branch(32'h1000, 32'h800, BR_BEQ, 1'b1, 1'b0, 32'd0, 32'd1, 0, 0, 0);
        check("t7 redir_pc", seen_pc, 32'h1800);
        tick();

        // unsigned compares
        run_branch(32'h2000, 32'h4, BR_BLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
        run_branch(32'h2004, 32'h4, BR_BGEU, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1, 0, 0);
        check("t8 stat_br",  bus.stat_br_cnt, 32'd8);
        check("t8 stat_mis", bus.stat_mispred_cnt, 32'd4);

        // drive the 4-bit counters into saturation
        for (int i = 0; i < 10; i++)
            run_branch(32'h3000 + 32'(i * 4), 32'h10, BR_BEQ, 1'b0, 1'b1, 32'(i), 32'(i), 0, 0, 0);
        for (int i = 0; i < 12; i++)
            run_branch(32'h4000, 32'(i * 16), BR_BEQ, 1'b1, 1'b0, 32'd0, 32'd0, 0, 0, 0);
        tick();
        check("t9 stat_br",    bus.stat_br_cnt, 32'd30);
        check("t9 stat_mis",   bus.stat_mispred_cnt, 32'd16);
        check("t9 s_br sat",   bus_s.stat_br_cnt, 32'hF);
        check("t9 s_mis sat",  bus_s.stat_mispred_cnt, 32'hF);

        // async reset while a redirect is pending
        bus.in_valid = 1'b1;  bus.in_pc = 32'h5000;  bus.in_imm = 32'h10;
        bus.in_uncond = 1'b1;  bus.in_pred_taken = 1'b0;
        tick();
        bus.in_valid = 1'b0;  bus.in_uncond = 1'b0;
        e_busy = 1'b1;
        tick();
        tick();
        e_br++;  e_mis++;  e_redir = 1'b1;  e_pc = 32'h5010;
        check("t10 redir_valid", bus.redir_valid, 32'd1);
        check("t10 redir_pc",    bus.redir_pc, 32'h5010);
        #2;
        rst_n = 1'b0;
        e_busy = 1'b0;  e_redir = 1'b0;  e_flush = 1'b0;  e_br = 0;  e_mis = 0;
        #1;
        check("t10 rst redir_valid", bus.redir_valid, 32'd0);
        check("t10 rst redir_pc",    bus.redir_pc, 32'd0);
        check("t10 rst busy",        bus.busy, 32'd0);
        check("t10 rst in_ready",    bus.in_ready, 32'd1);
        check("t10 rst stat_br",     bus.stat_br_cnt, 32'd0);
        check("t10 rst stat_mis",    bus.stat_mispred_cnt, 32'd0);
        n_flush = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("t10 no flush", 32'(n_flush), 32'd0);

        run_branch(32'h6000, 32'h20, BR_BNE, 1'b0, 1'b0, 32'd1, 32'd1, 0, 0, 0);
        check("t11 stat_br", bus.stat_br_cnt, 32'd1);
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
